// File: rtl/ram_line_mover.sv
// ram_line_mover: line-granular sequencer for port 0 (read-write) of a 1rw1r
// cache data RAM. One whole-line request is accepted per handshake. A fill
// streams wdat beats into the RAM. A readout streams a line out onto rdat
// with full backpressure. The read-only RAM port is left to the pipeline.
//
// Ports:
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_req_valid/o_req_ready             line request handshake
//   i_req_wr, i_req_line                1 = fill, 0 = readout; line index
//   i_wdat_valid/o_wdat_ready, i_wdat   fill beat channel
//   o_rdat_valid/i_rdat_ready, o_rdat   readout beat channel
//   o_rdat_last                         marks the final beat of a line
//   o_done                              one-cycle completion pulse
//   o_ram_addr0, o_ram_re0, o_ram_we0   RAM port 0 control
//   o_ram_wr0, i_ram_rd0                RAM port 0 write / read data
module ram_line_mover #(
  parameter int unsigned DBITS = 64,
  parameter int unsigned ABITS = 9,
  parameter int unsigned LBITS = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_wr,
  input  logic [ABITS-LBITS-1:0] i_req_line,
  input  logic                   i_wdat_valid,
  output logic                   o_wdat_ready,
  input  logic [DBITS-1:0]       i_wdat,
  output logic                   o_rdat_valid,
  input  logic                   i_rdat_ready,
  output logic [DBITS-1:0]       o_rdat,
  output logic                   o_rdat_last,
  output logic                   o_done,
  output logic [ABITS-1:0]       o_ram_addr0,
  output logic                   o_ram_re0,
  output logic                   o_ram_we0,
  output logic [DBITS-1:0]       o_ram_wr0,
  input  logic [DBITS-1:0]       i_ram_rd0
);

  localparam int unsigned LineW = ABITS - LBITS;

  typedef enum logic [1:0] {StIdle, StFill, StRead, StDrain} state_e;

  state_e             r_state, w_state_nxt;
  logic [LineW-1:0]   r_line, w_line_nxt;
  logic [LBITS-1:0]   r_beat, w_beat_nxt;
  logic               r_rdat_valid, w_rdat_valid_nxt;
  logic               r_rdat_last, w_rdat_last_nxt;
  logic               r_done, w_done_nxt;

  logic               w_last_beat;
  logic               w_issue;
  logic               w_write;
  logic               w_rd_hs;

  assign w_last_beat = (r_beat == {LBITS{1'b1}});
  // A read is issued only when the output register is empty or being drained,
  // so ram_rd0 (and rdat) holds steady while the consumer stalls.
  assign w_issue     = (r_state == StRead) && (!r_rdat_valid || i_rdat_ready);
  assign w_write     = (r_state == StFill) && i_wdat_valid;
  assign w_rd_hs     = r_rdat_valid && i_rdat_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_line       <= '0;
      r_beat       <= '0;
      r_rdat_valid <= 1'b0;
      r_rdat_last  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_line       <= w_line_nxt;
      r_beat       <= w_beat_nxt;
      r_rdat_valid <= w_rdat_valid_nxt;
      r_rdat_last  <= w_rdat_last_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_line_nxt       = r_line;
    w_beat_nxt       = r_beat;
    w_rdat_valid_nxt = r_rdat_valid;
    w_rdat_last_nxt  = r_rdat_last;
    w_done_nxt       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_line_nxt  = i_req_line;
          w_beat_nxt  = '0;
          w_state_nxt = i_req_wr ? StFill : StRead;
        end
      end
      StFill: begin
        if (w_write) begin
          w_beat_nxt = r_beat + LBITS'(1);
          if (w_last_beat) begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end
        end
      end
      StRead: begin
        if (w_issue) begin
          w_beat_nxt = r_beat + LBITS'(1);
          if (w_last_beat) w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (w_rd_hs && r_rdat_last) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_issue) begin
      w_rdat_valid_nxt = 1'b1;
      w_rdat_last_nxt  = w_last_beat;
    end else if (w_rd_hs) begin
      w_rdat_valid_nxt = 1'b0;
      w_rdat_last_nxt  = 1'b0;
    end
  end

  // Output logic
  always_comb begin
    o_req_ready  = (r_state == StIdle);
    o_wdat_ready = (r_state == StFill);
    o_ram_we0    = w_write;
    o_ram_re0    = w_issue;
    o_ram_addr0  = {r_line, r_beat};
    o_ram_wr0    = i_wdat;
    o_rdat       = i_ram_rd0;
    o_rdat_valid = r_rdat_valid;
    o_rdat_last  = r_rdat_last;
    o_done       = r_done;
  end

endmodule

// File: tb/tb_ram_line_mover.sv
module tb_ram_line_mover;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [6:0]  req_line = '0;
  logic        wdat_valid = 1'b0;
  logic        wdat_ready;
  logic [63:0] wdat = '0;
  logic        rdat_valid;
  logic        rdat_ready = 1'b0;
  logic [63:0] rdat;
  logic        rdat_last;
  logic        done;
  logic [8:0]  ram_addr0;
  logic        ram_re0;
  logic        ram_we0;
  logic [63:0] ram_wr0;
  logic [63:0] ram_rd0 = '0;

  logic [63:0] mem [512];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // RAM port 0 model: 1-cycle read latency, output held while re is low.
  always @(posedge clk) begin
    if (ram_we0) mem[ram_addr0] <= ram_wr0;
    if (ram_re0) ram_rd0 <= mem[ram_addr0];
  end

  ram_line_mover #(.DBITS(64), .ABITS(9), .LBITS(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_wr     (req_wr),
    .i_req_line   (req_line),
    .i_wdat_valid (wdat_valid),
    .o_wdat_ready (wdat_ready),
    .i_wdat       (wdat),
    .o_rdat_valid (rdat_valid),
    .i_rdat_ready (rdat_ready),
    .o_rdat       (rdat),
    .o_rdat_last  (rdat_last),
    .o_done       (done),
    .o_ram_addr0  (ram_addr0),
    .o_ram_re0    (ram_re0),
    .o_ram_we0    (ram_we0),
    .o_ram_wr0    (ram_wr0),
    .i_ram_rd0    (ram_rd0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if ({req_ready, wdat_ready, ram_re0, ram_we0, rdat_valid, rdat_last, done} !== 7'b1000000) begin
      $display("FAIL reset_outputs got=%b want=1000000",
               {req_ready, wdat_ready, ram_re0, ram_we0, rdat_valid, rdat_last, done});
      bad++;
    end
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      $display("FAIL reset_release req_ready=%b done=%b want 1,0", req_ready, done);
      bad++;
    end
  endtask

  task automatic test_fill(input string name, input logic [6:0] line, input logic [255:0] d,
                           input logic [7:0] vpat, input int plen, input int exp_cycles);
    int k = 0;
    int c = 0;
    req_valid = 1'b1; req_wr = 1'b1; req_line = line;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      $display("FAIL %s req_ready got=%b want=1", name, req_ready); bad++;
    end
    step();
    req_valid = 1'b0;
    while (k < 4 && c < 40) begin
      wdat_valid = vpat[c % plen];
      wdat = d[k*64 +: 64];
      #1;
      total++;
      if (wdat_ready !== 1'b1 || ram_we0 !== wdat_valid || ram_re0 !== 1'b0) begin
        $display("FAIL %s fill_ctrl cyc=%0d wdat_ready=%b we=%b re=%b want 1,%b,0",
                 name, c, wdat_ready, ram_we0, ram_re0, wdat_valid);
        bad++;
      end
      if (wdat_valid) begin
        total++;
        if (ram_addr0 !== {line, k[1:0]} || ram_wr0 !== d[k*64 +: 64]) begin
          $display("FAIL %s fill_beat%0d addr=%0d data=%h want addr=%0d data=%h",
                   name, k, ram_addr0, ram_wr0, {line, k[1:0]}, d[k*64 +: 64]);
          bad++;
        end
      end
      step();
      if (wdat_valid) k++;
      c++;
    end
    wdat_valid = 1'b0;
    total++;
    if (k != 4 || c != exp_cycles) begin
      $display("FAIL %s fill_cycles beats=%0d cycles=%0d want 4,%0d", name, k, c, exp_cycles);
      bad++;
    end
    #1;
    total++;
    if (done !== 1'b1 || req_ready !== 1'b1 || wdat_ready !== 1'b0) begin
      $display("FAIL %s fill_done done=%b req_ready=%b wdat_ready=%b want 1,1,0",
               name, done, req_ready, wdat_ready);
      bad++;
    end
    step();
    total++;
    if (done !== 1'b0) begin
      $display("FAIL %s done_pulse got=%b want=0", name, done); bad++;
    end
  endtask

  task automatic test_read(input string name, input logic [6:0] line, input logic [255:0] d,
                           input logic [7:0] rpat, input int plen);
    int k = 0;
    int c = 0;
    logic prev_stall = 1'b0;
    logic [63:0] prev = '0;
    req_valid = 1'b1; req_wr = 1'b0; req_line = line;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      $display("FAIL %s req_ready got=%b want=1", name, req_ready); bad++;
    end
    step();
    req_valid = 1'b0;
    while (k < 4 && c < 60) begin
      rdat_ready = rpat[c % plen];
      #1;
      total++;
      if (ram_we0 !== 1'b0 || (rdat_valid && !rdat_ready && ram_re0)) begin
        $display("FAIL %s read_port cyc=%0d we=%b re=%b valid=%b ready=%b",
                 name, c, ram_we0, ram_re0, rdat_valid, rdat_ready);
        bad++;
      end
      if (prev_stall) begin
        total++;
        if (rdat_valid !== 1'b1 || rdat !== prev) begin
          $display("FAIL %s stall_hold cyc=%0d valid=%b rdat=%h want 1,%h",
                   name, c, rdat_valid, rdat, prev);
          bad++;
        end
      end
      if (rdat_valid && rdat_ready) begin
        total++;
        if (rdat !== d[k*64 +: 64] || rdat_last !== (k == 3)) begin
          $display("FAIL %s beat%0d rdat=%h last=%b want %h,%b",
                   name, k, rdat, rdat_last, d[k*64 +: 64], (k == 3));
          bad++;
        end
        if (plen == 1) begin
          total++;
          if (c != k + 1) begin
            $display("FAIL %s beat%0d_timing cyc=%0d want %0d", name, k, c, k + 1); bad++;
          end
        end
        k++;
      end
      prev_stall = rdat_valid && !rdat_ready;
      prev = rdat;
      step();
      c++;
    end
    rdat_ready = 1'b0;
    total++;
    if (k != 4) begin
      $display("FAIL %s beats got=%0d want=4", name, k); bad++;
    end
    #1;
    total++;
    if (done !== 1'b1 || rdat_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL %s read_done done=%b valid=%b req_ready=%b want 1,0,1",
               name, done, rdat_valid, req_ready);
      bad++;
    end
    step();
    total++;
    if (done !== 1'b0) begin
      $display("FAIL %s done_pulse got=%b want=0", name, done); bad++;
    end
  endtask

  // Fill line 0, then present the readout request on the done cycle.
  task automatic test_back_to_back();
    logic [255:0] d = {64'hA3A3, 64'hA2A2, 64'hA1A1, 64'hA0A0};
    int k = 0;
    int c = 0;
    req_valid = 1'b1; req_wr = 1'b1; req_line = 7'd0;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wdat_valid = 1'b1; wdat = d[i*64 +: 64];
      step();
    end
    wdat_valid = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_line = 7'd0;
    #1;
    total++;
    if (done !== 1'b1 || req_ready !== 1'b1) begin
      $display("FAIL b2b_accept done=%b req_ready=%b want 1,1", done, req_ready); bad++;
    end
    step();
    req_valid = 1'b0;
    rdat_ready = 1'b1;
    while (k < 4 && c < 20) begin
      #1;
      total++;
      if (ram_re0 && ram_we0) begin
        $display("FAIL b2b_port_excl re=%b we=%b want not both", ram_re0, ram_we0); bad++;
      end
      if (rdat_valid) begin
        total++;
        if (rdat !== d[k*64 +: 64]) begin
          $display("FAIL b2b_beat%0d rdat=%h want %h", k, rdat, d[k*64 +: 64]); bad++;
        end
        k++;
      end
      step();
      c++;
    end
    rdat_ready = 1'b0;
    #1;
    total++;
    if (k != 4 || done !== 1'b1) begin
      $display("FAIL b2b_done beats=%0d done=%b want 4,1", k, done); bad++;
    end
    step();
  endtask

  task automatic test_reset_mid_read(input logic [255:0] d);
    int k = 0;
    int c = 0;
    req_valid = 1'b1; req_wr = 1'b0; req_line = 7'd3;
    step();
    req_valid = 1'b0;
    rdat_ready = 1'b1;
    while (k < 2 && c < 20) begin
      #1;
      if (rdat_valid) k++;
      if (k < 2) step();
      c++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (rdat_valid !== 1'b0 || ram_re0 !== 1'b0 || req_ready !== 1'b1 || k != 2) begin
      $display("FAIL mid_reset valid=%b re=%b req_ready=%b beats=%0d want 0,0,1,2",
               rdat_valid, ram_re0, req_ready, k);
      bad++;
    end
    rdat_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    test_read("read_after_reset", 7'd3, d, 8'b1, 1);
  endtask

  initial begin
    logic [255:0] d3;
    logic [255:0] d5;
    d3 = {64'h44, 64'h33, 64'h22, 64'h11};
    d5 = {64'h5D5D, 64'h5C5C, 64'h5B5B, 64'h5A5A};
    test_reset();
    test_fill("fill_l3", 7'd3, d3, 8'b1, 1, 4);
    test_read("read_l3", 7'd3, d3, 8'b1, 1);
    test_read("read_stall", 7'd3, d3, 8'b1001, 4);
    test_fill("fill_gaps", 7'd5, d5, 8'b0010_1101, 6, 6);
    test_read("read_l5", 7'd5, d5, 8'b1, 1);
    test_back_to_back();
    test_reset_mid_read(d3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
